uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter, successor to the fixed 8N1 UART TX.
- Accepts one character per AXI-Stream beat and serialises it LSB-first with configurable data width, parity mode and stop-bit count.
- Exact per-bit timing, synchronous reset and a busy flag.
- Sits between a stream source (FIFO, packetiser) and the FPGA TX pin.

Parameters:
- CLK_FREQ, 25_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. N_TICKS = CLK_FREQ/BAUD_RATE (integer divide), must be >= 2.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- axis_tdata  input  DATA_BITS  character to send.
- axis_tvalid  input  1  source has a character.
- axis_tready  output  1  block can accept a character.
- tx_data  output  1  serial line, idle high, registered.
- busy  output  1  high while a frame is on the line.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - On a clk edge with rst=1: state=IDLE, bit counter and tick counter = 0, tx_data=1, busy=0, shift register cleared.
  - axis_tready=0 while rst=1.
  - Reset mid-frame aborts the frame. tx_data is 1 on the cycle after the rst edge. No partial resume.
- States: IDLE, START, DATA, PAR, STOP.
- axis_tready = (state==IDLE) && !rst. Combinational from the state register only, never from tvalid.
- Handshake: transfer when axis_tvalid && axis_tready on a rising edge.
  - axis_tdata is captured into the shift register on that edge. Later changes on tdata are ignored.
  - tvalid without tready has no effect.
- Latency: tx_data goes 0 (start bit) on the edge of the handshake. It is visible in the cycle after the handshake.
- Bit timing: each line bit (start, data, parity, stop) is held for exactly N_TICKS clock cycles.
  - Tick counter runs 0..N_TICKS-1 and wraps to 0 on bit advance. Width $clog2(N_TICKS).
- START: after N_TICKS cycles, go to DATA and drive data bit 0.
- DATA: bits sent LSB first (bit i, i=0..DATA_BITS-1). After bit DATA_BITS-1 completes, go to PAR if PARITY!=0, else STOP.
- PAR:
  - even: parity bit = XOR of data bits.
  - odd: parity bit = ~XOR of data bits.
  - Computed from the captured word.
- STOP:
  - tx_data=1 for STOP_BITS*N_TICKS cycles, then go to IDLE.
  - On the last STOP cycle, the next state is IDLE. tready rises the cycle after the final stop tick.
- Frame length: N_TICKS*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles of line activity.
- Back-to-back: with tvalid held high, the next handshake occurs in the first IDLE cycle. Exactly one idle-high clock cycle separates frames.
- busy:
  - busy=1 from the cycle after the handshake through the last stop-bit cycle.
  - busy=0 in IDLE.
  - busy == !axis_tready outside reset.
- Unused states or illegal encodings go to IDLE with tx_data=1.

Test Plan:
Common bench parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000, so N_TICKS=10.
1. DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5.
   - tx_data low for cycles 1-10 after the handshake.
   - Then bits 1,0,1,0,0,1,0,1 for 10 cycles each, then high for 10.
   - tready rises at cycle 101. busy is high for exactly 100 cycles.
2. DATA_BITS=7, PARITY=2 (even); send 0x03.
   - Parity bit = 0.
   - Resend with PARITY=1 (odd): parity bit = 1.
   - Frame length = 100 cycles.
3. DATA_BITS=9, STOP_BITS=2; send 0x1FF then 0x000 with tvalid held high.
   - Stop is high for 20 cycles.
   - Exactly one idle cycle, then the second start bit.
   - Receiver model decodes 0x1FF then 0x000.
4. Change axis_tdata every cycle after the handshake of 0x3C.
   - Line still carries 0x3C.
   - tvalid asserted mid-frame produces no second handshake until IDLE.
5. Assert rst for 1 cycle during data bit 4.
   - tx_data=1 and busy=0 on the next cycle.
   - tready=0 during rst, then 1.
   - A fresh frame sent afterwards is well-formed.
6. Hold tvalid=0 for 1000 cycles after reset.
   - tx_data stays 1, tready stays 1, busy stays 0.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: AXI-Stream fed UART transmitter with configurable width, parity and stop bits
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] axis_tdata,
  input  logic                 axis_tvalid,
  output logic                 axis_tready,
  output logic                 tx_data,
  output logic                 busy
);
  localparam int N_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(N_TICKS);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_next;
  logic [TW-1:0] tick;
  logic [BW-1:0] bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic par, tx_next, bit_done, last_data, last_stop;
  assign bit_done = tick == TW'(N_TICKS - 1);
  assign last_data = bcnt == BW'(DATA_BITS - 1);
  assign last_stop = bcnt == BW'(STOP_BITS - 1);
  assign axis_tready = state == IDLE && !rst;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tick <= '0;
      bcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      tx_data <= 1'b1;
    end else begin
      state <= state_next;
      tx_data <= tx_next;
      tick <= (state == IDLE || bit_done) ? '0 : tick + TW'(1);
      if (axis_tready && axis_tvalid) begin
        shreg <= axis_tdata;
        par <= (PARITY == 1) ? ~^axis_tdata : ^axis_tdata;
      end else if (state == DATA && bit_done) begin
        shreg <= shreg >> 1;
      end
      // bcnt indexes data bits in DATA, then counts stop bits in STOP
      bcnt <= (state == DATA && bit_done) ? (last_data ? '0 : bcnt + BW'(1)) :
              (state == STOP && bit_done) ? bcnt + BW'(1) :
              (state == DATA || state == STOP) ? bcnt : '0;
    end
  end
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:  state_next = axis_tvalid ? START : IDLE;
      START: state_next = bit_done ? DATA : START;
      DATA:  state_next = !(bit_done && last_data) ? DATA : (PARITY != 0) ? PAR : STOP;
      PAR:   state_next = bit_done ? STOP : PAR;
      STOP:  state_next = (bit_done && last_stop) ? IDLE : STOP;
      default: state_next = IDLE;
    endcase
  end
  // tx_next is the line level for the following cycle, registered into tx_data
  always_comb begin
    tx_next = 1'b1;
    case (state)
      IDLE:  tx_next = !axis_tvalid;
      START: tx_next = bit_done ? shreg[0] : 1'b0;
      DATA:  tx_next = !bit_done ? shreg[0] : !last_data ? shreg[1] : (PARITY != 0) ? par : 1'b1;
      PAR:   tx_next = bit_done | par;
      default: tx_next = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench driving four configurations of uart_tx_cfg
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] txl, rdy, bsy;
  logic [3:0] vld = '0;
  logic [3:0][8:0] td = '0;
  int q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .axis_tdata(td[0][7:0]), .axis_tvalid(vld[0]), .axis_tready(rdy[0]),
    .tx_data(txl[0]), .busy(bsy[0]));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .axis_tdata(td[1][6:0]), .axis_tvalid(vld[1]), .axis_tready(rdy[1]),
    .tx_data(txl[1]), .busy(bsy[1]));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7o1 (
    .clk(clk), .rst(rst), .axis_tdata(td[2][6:0]), .axis_tvalid(vld[2]), .axis_tready(rdy[2]),
    .tx_data(txl[2]), .busy(bsy[2]));
  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_9n2 (
    .clk(clk), .rst(rst), .axis_tdata(td[3]), .axis_tvalid(vld[3]), .axis_tready(rdy[3]),
    .tx_data(txl[3]), .busy(bsy[3]));

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT idle; returns at the negedge of frame cycle 1
  task automatic send(input int k, input int w, input bit hold);
    checks++;
    if (rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL send_ready[%0d]: got %b expected 1", k, rdy[k]);
    end
    vld[k] = 1'b1;
    td[k] = 9'(w);
    q.push_back(w);
    @(negedge clk);
    if (!hold) vld[k] = 1'b0;
  endtask

  // Entered at the negedge of frame cycle 1; returns at the negedge of the idle cycle after the frame
  task automatic rx_frame(input int k, input int db, input int pm, input int sb);
    int nb, got, exp, bad_t, bad_b;
    logic bits[16];
    logic p;
    nb = 1 + db + (pm != 0 ? 1 : 0) + sb;
    bad_t = 0;
    bad_b = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < 10; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (c == 0) bits[b] = txl[k];
        else if (txl[k] !== bits[b]) bad_t++;
        if (bsy[k] !== 1'b1 || rdy[k] !== 1'b0) bad_b++;
      end
    end
    checks++;
    if (bits[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_bit[%0d]: got %b expected 0", k, bits[0]);
    end
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty[%0d]: got 0 entries expected 1", k);
      exp = 0;
    end else exp = q.pop_front();
    got = 0;
    for (int i = 0; i < db; i++) got |= int'(bits[1 + i]) << i;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL data[%0d]: got %0h expected %0h", k, got, exp);
    end
    if (pm != 0) begin
      p = 1'b0;
      for (int i = 0; i < db; i++) p ^= exp[i];
      if (pm == 1) p = ~p;
      checks++;
      if (bits[1 + db] !== p) begin
        errors++;
        $display("FAIL parity[%0d]: got %b expected %b", k, bits[1 + db], p);
      end
    end
    for (int s = 0; s < sb; s++) begin
      checks++;
      if (bits[nb - sb + s] !== 1'b1) begin
        errors++;
        $display("FAIL stop_bit[%0d.%0d]: got %b expected 1", k, s, bits[nb - sb + s]);
      end
    end
    checks++;
    if (bad_t != 0) begin
      errors++;
      $display("FAIL bit_timing[%0d]: got %0d unstable cycles expected 0", k, bad_t);
    end
    checks++;
    if (bad_b != 0) begin
      errors++;
      $display("FAIL busy_during_frame[%0d]: got %0d bad cycles expected 0", k, bad_b);
    end
    @(negedge clk);
    checks++;
    if (txl[k] !== 1'b1 || rdy[k] !== 1'b1 || bsy[k] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_frame[%0d]: got tx=%b rdy=%b busy=%b expected 1 1 0", k, txl[k], rdy[k], bsy[k]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (txl !== 4'hF || bsy !== 4'h0 || rdy !== 4'h0) begin
      errors++;
      $display("FAIL reset_state: got tx=%b busy=%b rdy=%b expected 1111 0000 0000", txl, bsy, rdy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy !== 4'hF) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1111", rdy);
    end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      checks++;
      if (txl[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL idle_hold: got tx=%b rdy=%b busy=%b expected 1 1 0", txl[0], rdy[0], bsy[0]);
      end
    end
  endtask

  task automatic test_8n1();
    send(0, 8'hA5, 1'b0);
    rx_frame(0, 8, 0, 1);
  endtask

  task automatic test_parity();
    send(1, 7'h03, 1'b0);
    rx_frame(1, 7, 2, 1);
    send(2, 7'h03, 1'b0);
    rx_frame(2, 7, 1, 1);
    send(1, 7'h55, 1'b0);
    rx_frame(1, 7, 2, 1);
  endtask

  task automatic test_back_to_back();
    send(3, 9'h1FF, 1'b1);
    td[3] = 9'h000;
    q.push_back(0);
    rx_frame(3, 9, 0, 2);
    @(negedge clk);
    vld[3] = 1'b0;
    rx_frame(3, 9, 0, 2);
  endtask

  task automatic test_tdata_hold();
    send(0, 8'h3C, 1'b0);
    fork
      rx_frame(0, 8, 0, 1);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        td[0] = 9'($urandom);
        if (i > 20) vld[0] = 1'b1;
      end
    join
    td[0] = 9'h05A;
    q.push_back(8'h5A);
    @(negedge clk);
    vld[0] = 1'b0;
    rx_frame(0, 8, 0, 1);
  endtask

  task automatic test_reset_mid_frame();
    send(0, 8'h00, 1'b0);
    repeat (54) @(negedge clk);
    checks++;
    if (txl[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_line: got tx=%b busy=%b expected 0 1", txl[0], bsy[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset: got %b expected 0", rdy[0]);
    end
    @(negedge clk);
    checks++;
    if (txl[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: got tx=%b busy=%b rdy=%b expected 1 0 0", txl[0], bsy[0], rdy[0]);
    end
    rst = 1'b0;
    q.delete();
    #1;
    checks++;
    if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_abort: got rdy=%b busy=%b expected 1 0", rdy[0], bsy[0]);
    end
    @(negedge clk);
    send(0, 8'h96, 1'b0);
    rx_frame(0, 8, 0, 1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_tdata_hold();
    test_reset_mid_frame();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
